// File: rtl/crc_pkg.sv
// crc_pkg: shared FSM state type and CRC-8 defaults for the framing controller.
package crc_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_OUT, ST_APPEND, ST_STATUS} state_t;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial MSB-first CRC-8 register, no reflection, no final XOR.
module crc8_serial import crc_pkg::*; #(
  parameter logic [7:0] POLY = CRC8_POLY,
  parameter logic [7:0] INIT = CRC8_INIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit_in,
  output logic [7:0] o_crc
);
  logic [7:0] r_crc;
  logic       w_fb;
  assign w_fb  = r_crc[7] ^ i_bit_in;
  assign o_crc = r_crc;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_crc <= INIT;
    else if (i_clr) r_crc <= INIT;
    else if (i_en) r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? POLY : 8'h00);
endmodule

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: byte-stream CRC-8 framer; appends CRC in gen mode,
// forwards and verifies the trailing CRC in check mode.
module crc_frame_ctrl import crc_pkg::*; #(
  parameter logic [7:0] POLY = CRC8_POLY,
  parameter logic [7:0] INIT = CRC8_INIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_mode_gen,
  input  logic       i_in_valid,
  input  logic [7:0] i_in_data,
  input  logic       i_in_last,
  output logic       o_in_ready,
  output logic       o_out_valid,
  output logic [7:0] o_out_data,
  output logic       o_out_last,
  input  logic       i_out_ready,
  output logic       o_status_valid,
  output logic       o_crc_ok
);
  state_t     r_state, w_next;
  logic [7:0] r_byte;
  logic [2:0] r_cnt;
  logic       r_last, r_mode, r_first;
  logic [7:0] w_crc;
  logic       w_clr, w_en, w_hs;
  assign w_hs = i_in_valid & o_in_ready;
  crc8_serial #(.POLY(POLY), .INIT(INIT)) u_crc (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(w_clr), .i_en(w_en),
    .i_bit_in(r_byte[~r_cnt]), .o_crc(w_crc)
  );
  always_comb begin
    w_next         = r_state;
    w_clr          = 1'b0;
    w_en           = 1'b0;
    o_in_ready     = 1'b0;
    o_out_valid    = 1'b0;
    o_out_data     = 8'h00;
    o_out_last     = 1'b0;
    o_status_valid = 1'b0;
    o_crc_ok       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        w_next     = i_in_valid ? ST_SHIFT : ST_IDLE;
      end
      ST_SHIFT: begin
        w_en   = 1'b1;
        w_next = (r_cnt == 3'd7) ? ST_OUT : ST_SHIFT;
      end
      ST_OUT: begin
        o_out_valid = 1'b1;
        o_out_data  = r_byte;
        o_out_last  = r_last & ~r_mode;
        w_next      = !i_out_ready ? ST_OUT : !r_last ? ST_IDLE : r_mode ? ST_APPEND : ST_STATUS;
      end
      ST_APPEND: begin
        o_out_valid = 1'b1;
        o_out_data  = w_crc;
        o_out_last  = 1'b1;
        w_clr       = i_out_ready;
        w_next      = i_out_ready ? ST_IDLE : ST_APPEND;
      end
      ST_STATUS: begin
        o_status_valid = 1'b1;
        o_crc_ok       = (w_crc == 8'h00);
        w_clr          = 1'b1;
        w_next         = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end
  // r_first marks that the next accepted byte opens a frame, so mode is sampled only then
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_byte  <= 8'h00;
      r_last  <= 1'b0;
      r_mode  <= 1'b0;
      r_first <= 1'b1;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_hs) {r_byte, r_last} <= {i_in_data, i_in_last};
      if (w_hs & r_first) r_mode <= i_mode_gen;
      r_first <= w_clr ? 1'b1 : w_hs ? 1'b0 : r_first;
      if (w_en) r_cnt <= r_cnt + 3'd1;
    end
endmodule

// File: doc/crc_frame_ctrl.md
CRC_FRAME_CTRL -- requirements
Module: crc_frame_ctrl

Interface
REQ-001: Parameter POLY, 8'h07, CRC-8 generator polynomial (x^8 implicit).
REQ-002: Parameter INIT, 8'h00, CRC register value at frame start.
REQ-003: clk  input  1  single clock for all logic; rising-edge.
REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005: mode_gen  input  1  1 = generate/append CRC, 0 = check trailing CRC; sampled on first byte of a frame.
REQ-006: in_valid  input  1  input byte valid.
REQ-007: in_data  input  8  input byte.
REQ-008: in_last  input  1  marks final input byte of a frame.
REQ-009: in_ready  output  1  block accepts a byte this cycle.
REQ-010: out_valid  output  1  output byte valid.
REQ-011: out_data  output  8  output byte.
REQ-012: out_last  output  1  marks final output byte of a frame.
REQ-013: out_ready  input  1  downstream accepts output byte.
REQ-014: status_valid  output  1  one-cycle pulse at end of a check-mode frame.
REQ-015: crc_ok  output  1  check result; valid only with status_valid.

Function
REQ-016: FSM states: IDLE, SHIFT, OUT, APPEND, STATUS.
REQ-017: in_ready SHALL be 1 only in IDLE; handshake = in_valid & in_ready; byte, in_last latched on handshake; state -> SHIFT.
REQ-018: First byte of a frame latches mode_gen; mode_gen changes mid-frame are ignored.
REQ-019: SHIFT lasts exactly 8 cycles, feeding latched byte MSB (bit 7) first to the CRC engine, one bit per cycle; 3-bit counter wraps 7->0 and moves to OUT.
REQ-020: CRC update per bit: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? POLY : 0); no reflection, no final XOR.
REQ-021: OUT: out_valid=1, out_data=latched byte, held stable until out_valid & out_ready.
REQ-022: Gen mode: out_last=0 on payload bytes; after last payload byte accepted -> APPEND: out_data=CRC, out_last=1, held until out_ready; then IDLE.
REQ-023: Check mode: all bytes (including trailing CRC byte) forwarded unchanged, out_last=1 on last; after it is accepted -> STATUS.
REQ-024: STATUS lasts one cycle: status_valid=1, crc_ok = (crc == 8'h00); then IDLE.
REQ-025: Non-last byte accepted in OUT -> IDLE, CRC retained.
REQ-026: CRC register reloads INIT on entering IDLE from APPEND or STATUS.
REQ-027: Single-byte check frame: crc_ok=1 only if remainder is zero (byte equals INIT-consistent CRC, i.e. 0x00 for INIT=0).
REQ-028: Minimum throughput 10 cycles/byte (1 accept + 8 shift + 1 output); back-pressure extends OUT/APPEND only.
REQ-029: in_valid while in_ready=0 SHALL have no effect; no byte lost or duplicated.

Reset
REQ-030: rst_n low: state=IDLE, crc=INIT, shift counter=0, all outputs 0 except in_ready=1 after release.
REQ-031: Reset mid-frame aborts the frame; no status pulse; next frame starts with fresh CRC.

Structure
REQ-032: Package crc_pkg holds FSM state enum, CRC8_POLY=8'h07, CRC8_INIT=8'h00.
REQ-033: Sub-module crc8_serial (inputs clr, en, bit_in; output crc[7:0]) implements REQ-020; controller instantiates it once.

Verification
REQ-034: Gen, bytes 31..39 (last on 39), out_ready=1 -> out 31..39 then F4 with out_last=1.
REQ-035: Check, bytes 31..39,F4 -> same 10 bytes forwarded, status_valid pulse with crc_ok=1.
REQ-036: Check, bytes 31..39,F5 -> status_valid pulse with crc_ok=0.
REQ-037: Gen, single byte 01 last -> out 01 (out_last=0), then 07 (out_last=1).
REQ-038: Gen byte 00, out_ready low 5 cycles in OUT -> out_data stable 00, in_ready=0 throughout, then 00 and CRC 00 delivered.
REQ-039: rst_n low during SHIFT cycle 4, then check frame 00 -> no earlier status pulse; crc_ok=1.
